// File: rtl/usr_pkg.sv
// Shared types and constants for the universal shift register.
package usr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } usr_state_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst sequencer: accepts start, counts shifts, latches direction/rotate, drives busy/done.
module usr_burst_ctrl
  import usr_pkg::*;
#(
  parameter int unsigned CW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          pl,
  input  logic          start,
  input  logic [CW-1:0] count,
  input  logic          right_left,
  input  logic          rotate,
  output logic          shift_req,
  output logic          burst_dir,
  output logic          burst_rot,
  output logic          busy,
  output logic          done
);

  usr_state_t    state, state_n;
  logic [CW-1:0] remaining, remaining_n;
  logic          dir_q, dir_n;
  logic          rot_q, rot_n;
  logic          done_q, done_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      dir_q     <= DIR_RIGHT;
      rot_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      dir_q     <= dir_n;
      rot_q     <= rot_n;
      done_q    <= done_n;
    end
  end

  // A parallel load aborts a burst silently, so it is checked before the burst step.
  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    dir_n       = dir_q;
    rot_n       = rot_q;
    done_n      = 1'b0;
    if (pl) begin
      state_n     = IDLE;
      remaining_n = '0;
    end else begin
      case (state)
        BURST: begin
          remaining_n = remaining - CW'(1);
          if (remaining == CW'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
        default: begin
          if (start) begin
            dir_n       = right_left;
            rot_n       = rotate;
            remaining_n = count;
            if (count == '0) done_n  = 1'b1;
            else             state_n = BURST;
          end
        end
      endcase
    end
  end

  assign busy      = (state == BURST);
  assign shift_req = busy && !pl;
  assign burst_dir = dir_q;
  assign burst_rot = rot_q;
  assign done      = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, manual and burst shifts.
// Optional rotate support is enabled by defining USR_ROTATE_EN.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             pl,
  input  logic             new_bit,
  input  logic             right_left,
  input  logic             rotate,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic [CW-1:0]    count,
  output logic             d_out,
  output logic [WIDTH-1:0] reg_bits,
  output logic             busy,
  output logic             done
);

  logic             shift_req;
  logic             burst_dir;
  logic             burst_rot;
  logic             manual_shift;
  logic             do_shift;
  logic             shift_left;
  logic             out_bit;
  logic             fill;
  logic [WIDTH-1:0] shifted;

  usr_burst_ctrl #(
    .CW(CW)
  ) u_ctrl (
    .clock      (clock),
    .reset      (reset),
    .pl         (pl),
    .start      (start),
    .count      (count),
    .right_left (right_left),
    .rotate     (rotate),
    .shift_req  (shift_req),
    .burst_dir  (burst_dir),
    .burst_rot  (burst_rot),
    .busy       (busy),
    .done       (done)
  );

  // A start accepted in idle suppresses the manual shift on the same edge.
  assign manual_shift = !busy && en && !start && !pl;
  assign do_shift     = shift_req || manual_shift;
  assign shift_left   = busy ? (burst_dir == DIR_LEFT) : (right_left == DIR_LEFT);
  assign out_bit      = shift_left ? reg_bits[WIDTH-1] : reg_bits[0];

`ifdef USR_ROTATE_EN
  logic rot_sel;
  assign rot_sel = busy ? burst_rot : rotate;
  assign fill    = rot_sel ? out_bit : new_bit;
`else
  logic unused_rotate;
  assign unused_rotate = burst_rot ^ rotate;
  assign fill          = new_bit;
`endif

  assign shifted = shift_left ? {reg_bits[WIDTH-2:0], fill}
                              : {fill, reg_bits[WIDTH-1:1]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_bits <= '0;
      d_out    <= 1'b0;
    end else if (pl) begin
      reg_bits <= din;
    end else if (do_shift) begin
      reg_bits <= shifted;
      d_out    <= out_bit;
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: vector table, directed corner cases, random vs model.
module tb_univ_shift_reg;

`ifdef USR_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic       en;
  logic       pl;
  logic       new_bit;
  logic       right_left;
  logic       rotate;
  logic [7:0] din;
  logic       start;
  logic [3:0] count;
  logic       d_out;
  logic [7:0] reg_bits;
  logic       busy;
  logic       done;

  int vectors;
  int miscompares;

  univ_shift_reg #(
    .WIDTH(8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .en         (en),
    .pl         (pl),
    .new_bit    (new_bit),
    .right_left (right_left),
    .rotate     (rotate),
    .din        (din),
    .start      (start),
    .count      (count),
    .d_out      (d_out),
    .reg_bits   (reg_bits),
    .busy       (busy),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       pl;
    logic       en;
    logic       nb;
    logic       rl;
    logic [7:0] din;
    logic [7:0] exp_reg;
    logic       exp_dout;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    en = 0; pl = 0; new_bit = 0; right_left = 0; rotate = 0;
    din = '0; start = 0; count = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    #12;
    reset = 0;
    #1;
  endtask

  // Reference: one shift of an 8-bit value, as plain arithmetic. Returns {out_bit, new_value}.
  function automatic logic [8:0] ref_shift(input logic [7:0] v, input logic left,
                                           input logic rot, input logic nb);
    int unsigned val;
    int unsigned outb;
    int unsigned f;
    int unsigned nv;
    val  = v;
    outb = left ? (val / 128) : (val % 2);
    f    = (ROT_EN && rot) ? outb : nb;
    nv   = left ? ((val * 2 + f) % 256) : (val / 2 + f * 128);
    return {outb[0], nv[7:0]};
  endfunction

  logic [7:0] m_reg;
  logic       m_dout;
  logic       m_busy;
  logic       m_done;
  int         m_rem;
  logic       m_dir;
  logic       m_rot;
  logic [8:0] sr;

  initial begin
    vectors = 0;
    miscompares = 0;
    idle_inputs();

    // Reset state
    do_reset();
    check("rst_reg", reg_bits, 8'h00);
    check("rst_dout", d_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    // Manual/load vector table
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h81, 8'h81, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h02, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h81, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h40, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h40, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 8'h3C, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h79, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'hBC, 1'b1};
    for (int i = 0; i < 8; i++) begin
      pl = tbl[i].pl; en = tbl[i].en; new_bit = tbl[i].nb;
      right_left = tbl[i].rl; din = tbl[i].din;
      step();
      check($sformatf("tbl%0d_reg", i), reg_bits, tbl[i].exp_reg);
      check($sformatf("tbl%0d_dout", i), d_out, tbl[i].exp_dout);
    end
    idle_inputs();

    // Load A5, manual left shift with fill 1
    pl = 1; din = 8'hA5; step(); pl = 0;
    check("pl_a5", reg_bits, 8'hA5);
    en = 1; right_left = 1; new_bit = 1; step(); idle_inputs();
    check("man_left_reg", reg_bits, 8'h4B);
    check("man_left_dout", d_out, 1'b1);

    // Right burst of 3 from A5
    pl = 1; din = 8'hA5; step(); pl = 0;
    start = 1; count = 3; right_left = 0; new_bit = 0; step(); start = 0;
    check("b3_accept_busy", busy, 1'b1);
    check("b3_accept_reg", reg_bits, 8'hA5);
    step(); check("b3_s1_busy", busy, 1'b1); check("b3_s1_reg", reg_bits, 8'h52);
    check("b3_s1_done", done, 1'b0);
    step(); check("b3_s2_busy", busy, 1'b1); check("b3_s2_reg", reg_bits, 8'h29);
    step(); check("b3_end_busy", busy, 1'b0); check("b3_end_done", done, 1'b1);
    check("b3_end_reg", reg_bits, 8'h14); check("b3_end_dout", d_out, 1'b1);
    step(); check("b3_done_once", done, 1'b0); check("b3_hold_reg", reg_bits, 8'h14);

    // Left rotate burst of 4 from A5 (plain fill 0 when rotate is compiled out)
    pl = 1; din = 8'hA5; step(); pl = 0;
    start = 1; count = 4; right_left = 1; rotate = 1; new_bit = 0; step();
    start = 0; rotate = 0; right_left = 0;
    for (int i = 0; i < 4; i++) step();
    check("rot4_reg", reg_bits, ROT_EN ? 8'h5A : 8'h50);
    check("rot4_done", done, 1'b1);
    idle_inputs();

    // Burst of 6 aborted by pl after 2 shifts
    pl = 1; din = 8'hFF; step(); pl = 0;
    start = 1; count = 6; step(); start = 0;
    step(); step();
    check("abort_pre_reg", reg_bits, 8'h3F);
    pl = 1; din = 8'h3C; step(); pl = 0;
    check("abort_reg", reg_bits, 8'h3C);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    step(); check("abort_done_after", done, 1'b0); check("abort_reg_hold", reg_bits, 8'h3C);

    // Zero-length start
    start = 1; count = 0; en = 1; step(); start = 0; en = 0;
    check("z_done", done, 1'b1); check("z_busy", busy, 1'b0); check("z_reg", reg_bits, 8'h3C);
    step(); check("z_done_once", done, 1'b0); check("z_busy2", busy, 1'b0);

    // start/right_left/en ignored while busy
    pl = 1; din = 8'h00; step(); pl = 0;
    start = 1; count = 3; right_left = 0; new_bit = 1; step();
    count = 7; right_left = 1; en = 1;
    step(); check("ign_s1_busy", busy, 1'b1);
    start = 0; en = 0;
    step(); check("ign_s2_busy", busy, 1'b1);
    step(); check("ign_end_busy", busy, 1'b0); check("ign_end_done", done, 1'b1);
    check("ign_end_reg", reg_bits, 8'hE0);
    idle_inputs();

    // Async reset mid-burst
    pl = 1; din = 8'hA5; step(); pl = 0;
    start = 1; count = 5; step(); start = 0;
    step(); step();
    #2 reset = 1; #1;
    check("arst_reg", reg_bits, 8'h00); check("arst_dout", d_out, 1'b0);
    check("arst_busy", busy, 1'b0); check("arst_done", done, 1'b0);
    #2 reset = 0;
    step(); step();
    check("arst_after_busy", busy, 1'b0); check("arst_after_done", done, 1'b0);

    // Randomised run against the reference model
    do_reset();
    m_reg = '0; m_dout = 0; m_busy = 0; m_done = 0; m_rem = 0; m_dir = 0; m_rot = 0;
    for (int i = 0; i < 600; i++) begin
      pl = ($urandom_range(0, 19) == 0);
      en = $urandom_range(0, 1);
      start = ($urandom_range(0, 4) == 0);
      count = 4'($urandom_range(0, 10));
      right_left = $urandom_range(0, 1);
      rotate = $urandom_range(0, 1);
      new_bit = $urandom_range(0, 1);
      din = 8'($urandom_range(0, 255));
      m_done = 0;
      if (pl) begin
        m_reg = din; m_busy = 0; m_rem = 0;
      end else if (m_busy) begin
        sr = ref_shift(m_reg, m_dir, m_rot, new_bit);
        m_reg = sr[7:0]; m_dout = sr[8];
        m_rem = m_rem - 1;
        if (m_rem == 0) begin m_busy = 0; m_done = 1; end
      end else if (start) begin
        m_dir = right_left; m_rot = rotate;
        if (count == 0) m_done = 1;
        else begin m_busy = 1; m_rem = count; end
      end else if (en) begin
        sr = ref_shift(m_reg, right_left, rotate, new_bit);
        m_reg = sr[7:0]; m_dout = sr[8];
      end
      step();
      check("rnd_reg", reg_bits, m_reg);
      check("rnd_dout", d_out, m_dout);
      check("rnd_busy", busy, m_busy);
      check("rnd_done", done, m_done);
    end
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register. Next generation of the 4-bit right/left shift register with parallel load. Adds generic width, an optional rotate mode and an autonomous burst mode that shifts a programmed number of positions with a busy/done handshake. Sits between parallel data sources and serial links; it is also the building block for serialisers in later labs.

## Interface
- WIDTH, default 8, register width in bits (≥2)
- CW, default $clog2(WIDTH+1), width of the burst count (derived; do not override)
- clock  in  1  rising-edge clock; the only clock
- reset  in  1  asynchronous, active-high; clears all state
- en  in  1  manual single-step shift enable (idle only)
- pl  in  1  parallel load strobe
- new_bit  in  1  serial fill bit for non-rotate shifts
- right_left  in  1  direction: 1 = left (toward MSB), 0 = right
- rotate  in  1  1 = vacated bit is the bit shifted out (active only with USR_ROTATE_EN)
- din  in  WIDTH  parallel load data
- start  in  1  begin burst of `count` shifts
- count  in  CW  burst length in shifts
- d_out  out  1  last bit shifted out (registered)
- reg_bits  out  WIDTH  register contents
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst end

## Operation
- Priority at each edge: reset > pl > burst shift > start accept > en manual shift > hold.
- Left shift: reg_bits <= {reg_bits[WIDTH-2:0], fill}; d_out <= old MSB. Right shift: reg_bits <= {fill, reg_bits[WIDTH-1:1]}; d_out <= old LSB.
- Fill is new_bit, or the outgoing bit when rotating.
- pl: reg_bits <= din; d_out holds. Any pl, idle or busy, takes effect.
- FSM states: IDLE, BURST.
- IDLE + start (pl low): latch right_left and rotate, load remaining <= count. Go to BURST if count ≠ 0. If count = 0, stay IDLE and pulse done. No shift happens on the accept edge.
- BURST: one shift per edge using the latched direction/rotate and the live new_bit; remaining decrements. On the edge where remaining = 1: shift, go to IDLE, done <= 1.
- start, en, right_left and rotate are ignored while busy.
- pl during BURST: load din, abort to IDLE, no done pulse.
- count > WIDTH is legal: the burst performs exactly count shifts.

## Timing
- Reset values: reg_bits = 0, d_out = 0, busy = 0, done = 0, state IDLE, remaining = 0.
- Reset asserted mid-burst clears everything immediately (async), with no done pulse.
- start accepted at edge N with count = k ≥ 1: shifts occur at edges N+1 … N+k. busy is high for cycles N+1 … N+k. done is high for the single cycle after edge N+k, coincident with busy falling.
- start with count = 0 at edge N: done is high for one cycle after N; busy stays 0.
- Manual en shift and pl: result visible one cycle after the edge.
- done is never high together with busy.

## Configuration
- USR_ROTATE_EN defined: rotate is honoured for both manual and burst shifts.
- USR_ROTATE_EN undefined: the rotate port remains but is ignored. Fill is always new_bit and no rotate logic is synthesised.

## Structure
- Shared package usr_pkg holds:
  - state typedef (IDLE, BURST)
  - direction constants DIR_LEFT = 1, DIR_RIGHT = 0
- Natural sub-module usr_burst_ctrl: the FSM, remaining counter and busy/done generation. It outputs a shift_req plus the latched direction/rotate. The top level holds the datapath.

## Test plan
- Reset, then release: reg_bits = 8'h00, d_out = 0, busy = 0, done = 0. Assert reset mid-burst: all outputs return to 0 asynchronously.
- pl with din = 8'hA5 -> next cycle reg_bits = 8'hA5. Then en = 1, right_left = 1, new_bit = 1 -> reg_bits = 8'h4B, d_out = 1.
- From 8'hA5: start, count = 3, right_left = 0, new_bit = 0 -> busy for 3 cycles, reg_bits = 8'h14, d_out = 1, done pulses once as busy falls.
- With USR_ROTATE_EN, from 8'hA5: left rotate burst count = 4 -> 8'h5A. Without the macro, same stimulus with new_bit = 0 -> 8'h50.
- Burst count = 6 from 8'hFF, pl with din = 8'h3C after 2 shifts -> reg_bits = 8'h3C, busy drops, no done pulse.
- start with count = 0 -> done pulses one cycle, busy stays 0, reg_bits unchanged. start pulsed while busy -> ignored; the original burst length is kept.
